// File: rtl/fpu_vec_sequencer.sv
// fpu_vec_sequencer: memory-side sequencer for a combinational vector fpu.
// Loads vector A (and B unless SMUL) from 16-bit word memory into Va/Vb,
// asserts one op strobe until fpu_done, then stores the result to addr_d
// (LANES words, or a single Sout word for VDOT).
// Optional feature: define FPU_SEQ_TIMEOUT_EN to bound the EXEC wait to TIMEOUT
// cycles; on expiry STORE is skipped and DONE reports err=1.
module fpu_vec_sequencer #(
    parameter int ADDR_W  = 16,
    parameter int LANES   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [ADDR_W-1:0]     addr_a,
    input  logic [ADDR_W-1:0]     addr_b,
    input  logic [ADDR_W-1:0]     addr_d,
    input  logic [15:0]           sa_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata,
    input  logic                  mem_ack,
    output logic [LANES*16-1:0]   Va,
    output logic [LANES*16-1:0]   Vb,
    output logic [15:0]           Sa,
    output logic                  VADD,
    output logic                  VDOT,
    output logic                  SMUL,
    input  logic                  fpu_done,
    input  logic [LANES*16-1:0]   Vout,
    input  logic [15:0]           Sout
);

    localparam int VW = LANES * 16;
    localparam int BW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_A, S_LOAD_B, S_EXEC, S_STORE, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          op_q;           // {VADD, VDOT, SMUL}
    logic [ADDR_W-1:0]   base_a_q, base_b_q, base_d_q;
    logic [BW-1:0]       beat_q;
    logic [VW-1:0]       result_q;
    logic                err_q;

    logic op_legal, beat_done, last_beat, store_last, exec_timeout;

    assign op_legal   = (op == 3'b100) || (op == 3'b010) || (op == 3'b001);
    assign beat_done  = mem_req & mem_ack;
    assign last_beat  = (beat_q == BW'(LANES - 1));
    // VDOT writes back a single scalar word
    assign store_last = op_q[1] ? (beat_q == '0) : last_beat;

`ifdef FPU_SEQ_TIMEOUT_EN
    localparam int EW = $clog2(TIMEOUT + 1);
    logic [EW-1:0] exec_cnt_q;

    assign exec_timeout = (state_q == S_EXEC) && !fpu_done &&
                          (exec_cnt_q == EW'(TIMEOUT - 1));

    // Count EXEC cycles; cleared whenever the FSM is elsewhere
    always_ff @(posedge clk) begin
        if (rst || state_q != S_EXEC) exec_cnt_q <= '0;
        else                          exec_cnt_q <= exec_cnt_q + 1'b1;
    end
`else
    logic unused_timeout;
    assign exec_timeout   = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start) state_d = op_legal ? S_LOAD_A : S_DONE;
            S_LOAD_A: if (beat_done && last_beat) state_d = op_q[0] ? S_EXEC : S_LOAD_B;
            S_LOAD_B: if (beat_done && last_beat) state_d = S_EXEC;
            S_EXEC: begin
                if (fpu_done)          state_d = S_STORE;
                else if (exec_timeout) state_d = S_DONE;
            end
            S_STORE:  if (beat_done && store_last) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode: memory bus, op strobes and status
    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = 1'b0;
        err       = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        VADD      = 1'b0;
        VDOT      = 1'b0;
        SMUL      = 1'b0;
        unique case (state_q)
            S_LOAD_A: begin
                mem_req  = 1'b1;
                mem_addr = base_a_q + ADDR_W'(beat_q);
            end
            S_LOAD_B: begin
                mem_req  = 1'b1;
                mem_addr = base_b_q + ADDR_W'(beat_q);
            end
            S_EXEC: {VADD, VDOT, SMUL} = op_q;
            S_STORE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = base_d_q + ADDR_W'(beat_q);
                mem_wdata = result_q[beat_q*16 +: 16];
            end
            S_DONE: begin
                done = 1'b1;
                err  = err_q;
            end
            default: ;
        endcase
    end

    // Command capture, operand loading, beat counter and error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            base_a_q <= '0;
            base_b_q <= '0;
            base_d_q <= '0;
            beat_q   <= '0;
            err_q    <= 1'b0;
            Va       <= '0;
            Vb       <= '0;
            Sa       <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: if (start) begin
                    op_q     <= op;
                    base_a_q <= addr_a;
                    base_b_q <= addr_b;
                    base_d_q <= addr_d;
                    Sa       <= sa_in;
                    beat_q   <= '0;
                    err_q    <= !op_legal;
                    // SMUL never loads B, so present a clean zero vector
                    if (op_legal && op[0]) Vb <= '0;
                end
                S_LOAD_A: if (beat_done) begin
                    Va[beat_q*16 +: 16] <= mem_rdata;
                    beat_q <= last_beat ? '0 : beat_q + 1'b1;
                end
                S_LOAD_B: if (beat_done) begin
                    Vb[beat_q*16 +: 16] <= mem_rdata;
                    beat_q <= last_beat ? '0 : beat_q + 1'b1;
                end
                S_EXEC: if (!fpu_done && exec_timeout) err_q <= 1'b1;
                S_STORE: if (beat_done) begin
                    beat_q <= store_last ? '0 : beat_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Capture the fpu result on the first fpu_done cycle of EXEC
    always_ff @(posedge clk) begin
        // NOTE: result_q has no reset: EXEC always writes it before STORE reads it.
        if (state_q == S_EXEC && fpu_done)
            result_q <= op_q[1] ? {{(VW-16){1'b0}}, Sout} : Vout;
    end

endmodule

// File: tb/tb_fpu_vec_sequencer.sv
// Self-checking bench for fpu_vec_sequencer: word memory with random ack stalls,
// a toy integer "fpu", and a transaction-level model that predicts every memory
// beat, operand vector, strobe window and done/err cycle.
module tb_fpu_vec_sequencer;

    localparam int LANES = 16;
    localparam int VW    = LANES * 16;
`ifdef FPU_SEQ_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [2:0]      op = '0;
    logic [15:0]     addr_a = '0, addr_b = '0, addr_d = '0, sa_in = '0;
    logic            busy, done, err, mem_req, mem_we;
    logic [15:0]     mem_addr, mem_wdata;
    logic [15:0]     mem_rdata = '0;
    logic            mem_ack = 1'b0;
    logic [VW-1:0]   Va, Vb, Vout;
    logic [15:0]     Sa, Sout;
    logic            VADD, VDOT, SMUL;
    logic            fpu_done = 1'b0;

    fpu_vec_sequencer #(.ADDR_W(16), .LANES(LANES), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .addr_a(addr_a), .addr_b(addr_b), .addr_d(addr_d), .sa_in(sa_in),
        .busy(busy), .done(done), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .Va(Va), .Vb(Vb), .Sa(Sa), .VADD(VADD), .VDOT(VDOT), .SMUL(SMUL),
        .fpu_done(fpu_done), .Vout(Vout), .Sout(Sout)
    );

    always #5 clk = ~clk;

    // Toy fpu: lane-wise integer add / scale, integer dot product (mod 2^16)
    always_comb begin
        Vout = '0;
        Sout = '0;
        for (int i = 0; i < LANES; i++) begin
            if (VADD)      Vout[16*i +: 16] = Va[16*i +: 16] + Vb[16*i +: 16];
            else if (SMUL) Vout[16*i +: 16] = 16'(Va[16*i +: 16] * Sa);
            if (VDOT)      Sout = Sout + 16'(Va[16*i +: 16] * Vb[16*i +: 16]);
        end
    end

    // ---------------- bench state ----------------
    logic [15:0] mem [65536];
    int  n_checks = 0;
    int  n_fail   = 0;
    bit  stall_en = 0;
    bit  fpu_never = 0;
    int  fpu_delay = 0;

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [15:0] data;
    } beat_t;

    beat_t         exp_q[$];
    beat_t         bt;
    bit            exp_busy = 0, done_due = 0, exp_err = 0, exec_exp = 0, held = 0, was_busy;
    int            rd_left = 0, exec_left = 0, wait_cnt = -1, fcnt = 0;
    logic [2:0]    exp_op = '0;
    logic [VW-1:0] exp_va = '0, exp_vb = '0;
    logic [15:0]   exp_sa = '0;
    logic          h_we;
    logic [15:0]   h_addr, h_wdata;

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction model: what an accepted command must do on the bus and to the fpu
    task automatic accept_cmd();
        logic [15:0] av, bv, acc;
        exp_busy = 1;
        exp_op   = op;
        exp_q.delete();
        if ($countones(op) != 1) begin
            done_due = 1;
            exp_err  = 1;
            rd_left  = 0;
        end else begin
            exp_err = 0;
            exp_sa  = sa_in;
            exp_vb  = '0;
            acc     = '0;
            rd_left = op[0] ? LANES : 2 * LANES;
            for (int i = 0; i < LANES; i++) exp_q.push_back('{0, 16'(addr_a + i), 16'h0});
            if (!op[0])
                for (int i = 0; i < LANES; i++) exp_q.push_back('{0, 16'(addr_b + i), 16'h0});
            for (int i = 0; i < LANES; i++) begin
                av = mem[16'(addr_a + i)];
                bv = op[0] ? 16'h0 : mem[16'(addr_b + i)];
                exp_va[16*i +: 16] = av;
                exp_vb[16*i +: 16] = bv;
                acc = acc + 16'(av * bv);
                if (!fpu_never && !op[1])
                    exp_q.push_back('{1, 16'(addr_d + i), op[2] ? 16'(av + bv) : 16'(av * sa_in)});
            end
            if (!fpu_never && op[1]) exp_q.push_back('{1, addr_d, acc});
        end
    endtask

    // Per-cycle compare, memory responder and fpu_done driver
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("busy", busy, exp_busy);
                check("done", done, done_due);
                check("err", err, done_due ? exp_err : 1'b0);
                check("strobe", {VADD, VDOT, SMUL}, exec_exp ? exp_op : 3'b000);
                if (exec_exp) begin
                    check("Va", Va, exp_va);
                    check("Vb", Vb, exp_vb);
                    check("Sa", Sa, exp_sa);
                end
                if (!exp_busy) check("idle_req", mem_req, 1'b0);
                if (held) check("stall_hold", {mem_req, mem_we, mem_addr, mem_wdata},
                                {1'b1, h_we, h_addr, h_wdata});
            end
            // drive memory response and fpu_done for this cycle
            if (mem_req && !rst) begin
                if (wait_cnt < 0) wait_cnt = stall_en ? int'($urandom_range(0, 3)) : 0;
                if (wait_cnt == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr];
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = 16'($urandom);
                    wait_cnt--;
                end
            end else begin
                mem_ack  = 1'b0;
                wait_cnt = -1;
            end
            if (VADD || VDOT || SMUL) begin
                fcnt++;
                fpu_done = !fpu_never && (fcnt > fpu_delay);
            end else begin
                fcnt     = 0;
                fpu_done = 1'b0;
            end
            #1;
            // apply the coming clock edge to the model
            was_busy = exp_busy;
            if (rst) begin
                exp_q.delete();
                exp_busy = 0; done_due = 0; exec_exp = 0; held = 0; wait_cnt = -1;
            end else begin
                if (done_due) begin
                    exp_busy = 0;
                    done_due = 0;
                end
                if (exec_exp) begin
                    if (fpu_never) begin
                        exec_left--;
                        if (exec_left == 0) begin
                            exec_exp = 0;
                            done_due = 1;
                            exp_err  = 1;
                        end
                    end else if (fpu_done) begin
                        exec_exp = 0;
                    end
                end
                if (was_busy && mem_req && mem_ack) begin
                    held     = 0;
                    wait_cnt = -1;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_beat: addr %0h we %0b, no beat expected", mem_addr, mem_we);
                    end else begin
                        bt = exp_q.pop_front();
                        check("beat_we", mem_we, bt.we);
                        check("beat_addr", mem_addr, bt.addr);
                        if (bt.we) begin
                            check("beat_wdata", mem_wdata, bt.data);
                            mem[mem_addr] = mem_wdata;
                            if (exp_q.size() == 0) done_due = 1;
                        end else begin
                            rd_left--;
                            if (rd_left == 0) begin
                                exec_exp  = 1;
                                exec_left = TB_TIMEOUT;
                            end
                        end
                    end
                end else if (was_busy && mem_req && !mem_ack && !held) begin
                    held    = 1;
                    h_we    = mem_we;
                    h_addr  = mem_addr;
                    h_wdata = mem_wdata;
                end
                if (!was_busy && start) accept_cmd();
            end
        end
    end

    // Issue one command and return the cycle (counted from the accepting edge) of done
    task automatic run_op(input logic [2:0] o, input logic [15:0] a, b, d, s,
                          input bit stall, input int delay, output int dcyc, output logic derr);
        bit legal;
        legal = ($countones(o) == 1);
        @(negedge clk);
        op = o; addr_a = a; addr_b = b; addr_d = d; sa_in = s;
        stall_en = stall; fpu_delay = delay; start = 1'b1;
        dcyc = -1;
        derr = 1'b0;
        for (int n = 1; n <= 3000; n++) begin
            @(negedge clk);
            if (n == 1) begin
                op = 3'($urandom); addr_a = 16'($urandom); addr_b = 16'($urandom);
                addr_d = 16'($urandom); sa_in = 16'($urandom);
            end
            start = legal && (n >= 3) && (n <= 5);
            if (done) begin
                dcyc = n;
                derr = err;
                break;
            end
        end
        start = 1'b0;
        if (dcyc < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_wait: no done within 3000 cycles for op %0b", o);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ctrl"}, {busy, done, err, mem_req, mem_we, VADD, VDOT, SMUL}, 8'h00);
        check({tag, "_bus"}, {mem_addr, mem_wdata}, 32'h0);
        check({tag, "_Va"}, Va, '0);
        check({tag, "_Vb"}, Vb, '0);
        check({tag, "_Sa"}, Sa, 16'h0);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int          dc;
        logic        de;
        logic [2:0]  o;
        logic [15:0] a, b;
        logic [2:0]  illegal_ops [5];
        illegal_ops = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        // VADD: A = 1..16, B = 16..1 so every lane sums to 17
        for (int i = 0; i < LANES; i++) begin
            mem[16'h0000 + i] = 16'(i + 1);
            mem[16'h0100 + i] = 16'(16 - i);
        end
        run_op(3'b100, 16'h0000, 16'h0100, 16'h0200, 16'h0, 0, 0, dc, de);
        check("vadd_latency", dc, 50);
        check("vadd_err", de, 1'b0);
        check("vadd_lane0", mem[16'h0200], 16'd17);
        check("vadd_lane15", mem[16'h020F], 16'd17);

        // SMUL by 0x4000: lane1 = 2*0x4000 = 0x8000; B never read, Vb cleared
        run_op(3'b001, 16'h0000, 16'h0100, 16'h0300, 16'h4000, 0, 0, dc, de);
        check("smul_latency", dc, 34);
        check("smul_lane0", mem[16'h0300], 16'h4000);
        check("smul_lane1", mem[16'h0301], 16'h8000);
        check("smul_Vb", Vb, '0);
        check("smul_Sa", Sa, 16'h4000);

        // VDOT with B = all ones: 1+2+...+16 = 136; only addr_d written
        for (int i = 0; i < LANES; i++) mem[16'h0100 + i] = 16'h0001;
        mem[16'h0401] = 16'hDEAD;
        run_op(3'b010, 16'h0000, 16'h0100, 16'h0400, 16'h0, 0, 0, dc, de);
        check("vdot_latency", dc, 35);
        check("vdot_result", mem[16'h0400], 16'h0088);
        check("vdot_no_lane1", mem[16'h0401], 16'hDEAD);

        // Illegal op: no memory traffic, done+err one cycle after start
        run_op(3'b110, 16'h0000, 16'h0100, 16'h0500, 16'h0, 0, 0, dc, de);
        check("illegal_latency", dc, 1);
        check("illegal_err", de, 1'b1);

        // Randomized commands with ack stalls and fpu latency
        for (int k = 0; k < 40; k++) begin
            a = 16'($urandom);
            b = 16'(a + 32 + $urandom_range(0, 4000));
            for (int i = 0; i < LANES; i++) begin
                mem[16'(a + i)] = 16'($urandom);
                mem[16'(b + i)] = 16'($urandom);
            end
            case ($urandom_range(0, 7))
                0, 1, 2: o = 3'b100;
                3, 4:    o = 3'b010;
                5, 6:    o = 3'b001;
                default: o = illegal_ops[$urandom_range(0, 4)];
            endcase
            run_op(o, a, b, 16'(a + 16'h8000), 16'($urandom), 1, int'($urandom_range(0, 3)), dc, de);
        end

        // Reset in the middle of a VADD at cycle 20
        for (int i = 0; i < LANES; i++) mem[16'h0100 + i] = 16'(3 * i);
        @(negedge clk);
        op = 3'b100; addr_a = 16'h0000; addr_b = 16'h0100; addr_d = 16'h0600;
        stall_en = 0; fpu_delay = 0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("midop_reset");
        rst = 1'b0;
        run_op(3'b010, 16'h0000, 16'h0100, 16'h0700, 16'h0, 0, 0, dc, de);
        check("post_reset_latency", dc, 35);

`ifdef FPU_SEQ_TIMEOUT_EN
        // fpu never answers: 4 EXEC cycles, no writes, DONE with err
        mem[16'h0800] = 16'hBEEF;
        @(negedge clk);
        fpu_never = 1;
        run_op(3'b100, 16'h0000, 16'h0100, 16'h0800, 16'h0, 0, 0, dc, de);
        check("timeout_latency", dc, 37);
        check("timeout_err", de, 1'b1);
        check("timeout_no_write", mem[16'h0800], 16'hBEEF);
        @(negedge clk);
        fpu_never = 0;
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
